// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : bpu_pkg
// Desc   : Types and constants shared by the branch predictor and the resolver
// Rev    : 1.0
// ============================================================================
package bpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] inst_bus_t;

  localparam inst_bus_t PC_INC = 32'd4;

  typedef struct packed {
    inst_bus_t pc;
    logic      taken;
    inst_bus_t target;
    logic      mispredict;
  } upd_pkt_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_unit_if
// Desc   : Execute-side resolve bus, flush/redirect and predictor update channel
// Rev    : 1.0
// ============================================================================
interface branch_resolve_unit_if #(
  parameter int CNT_WIDTH = 32
);
  import bpu_pkg::*;

  logic                 ex_valid;
  inst_bus_t            ex_pc;
  logic                 ex_is_branch;
  logic                 ex_pred_taken;
  inst_bus_t            ex_pred_target;
  logic                 ex_actual_taken;
  inst_bus_t            ex_actual_target;
  logic                 flush;
  inst_bus_t            redirect_pc;
  logic                 upd_valid;
  logic                 upd_ready;
  inst_bus_t            upd_pc;
  inst_bus_t            upd_target;
  logic                 upd_taken;
  logic                 upd_mispredict;
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] mispred_cnt;
  logic [CNT_WIDTH-1:0] drop_cnt;

  modport master (
    output ex_valid, ex_pc, ex_is_branch, ex_pred_taken, ex_pred_target,
           ex_actual_taken, ex_actual_target, upd_ready,
    input  flush, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, branch_cnt, mispred_cnt, drop_cnt
  );

  modport slave (
    input  ex_valid, ex_pc, ex_is_branch, ex_pred_taken, ex_pred_target,
           ex_actual_taken, ex_actual_target, upd_ready,
    output flush, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, branch_cnt, mispred_cnt, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/bru_fifo.sv
`default_nettype none
// ============================================================================
// Module : bru_fifo
// Desc   : Synchronous FIFO, no bypass; head data reads as zero when empty
// Rev    : 1.0
// ============================================================================
module bru_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full queue still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_unit
// Desc   : Mispredict detection, flush/redirect generation and predictor training
// Rev    : 1.0
// ============================================================================
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);

  localparam int PKT_W = $bits(upd_pkt_t);

  logic                 flush_q, flush_d;
  inst_bus_t            redirect_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic       accept, mispredict, push, pop, full, empty;
  inst_bus_t  redirect_target;
  upd_pkt_t   push_pkt, head_pkt;
  logic [PKT_W-1:0] head_bits;

  // The instruction right behind a mispredict is wrong-path and is ignored.
  assign accept = bus.ex_valid && !flush_q;

  assign mispredict =
      ( bus.ex_is_branch && (bus.ex_pred_taken != bus.ex_actual_taken)) ||
      ( bus.ex_is_branch && bus.ex_pred_taken && bus.ex_actual_taken &&
        (bus.ex_pred_target != bus.ex_actual_target)) ||
      (!bus.ex_is_branch && bus.ex_pred_taken);

  assign redirect_target = (bus.ex_actual_taken && bus.ex_is_branch) ?
                           bus.ex_actual_target : bus.ex_pc + PC_INC;

  assign push_pkt = '{pc:         bus.ex_pc,
                      taken:      bus.ex_actual_taken & bus.ex_is_branch,
                      target:     bus.ex_actual_target,
                      mispredict: mispredict};

  assign push    = accept && (bus.ex_is_branch || mispredict);
  assign pop     = !empty && bus.upd_ready;
  assign flush_d = accept && mispredict;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    if (accept && bus.ex_is_branch && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    if (flush_d && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    if (push && full && !pop && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      flush_q       <= flush_d;
      if (flush_d) redirect_q <= redirect_target;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  bru_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_pkt),
    .pop_i   (pop),
    .data_o  (head_bits),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_pkt = upd_pkt_t'(head_bits);

  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_q;
  assign bus.upd_valid      = !empty;
  assign bus.upd_pc         = head_pkt.pc;
  assign bus.upd_taken      = head_pkt.taken;
  assign bus.upd_target     = head_pkt.target;
  assign bus.upd_mispredict = head_pkt.mispredict;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;
  assign bus.drop_cnt       = drop_cnt_q;

endmodule
`default_nettype wire
